// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer SRAM between 1bpp 640x480 VGA scanout (priority) and host writes; define VGA_FB_DOUBLE_BUFFER_EN to enable page_sel page flipping
module vga_fb_arbiter #(
  parameter int LINE_WORDS = 40,
  parameter int FETCH_OFS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        p_tick,
  input  logic        page_sel,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        pix
);
  logic [9:0] ny, line, word;
  logic phase, word_slot, line_slot, slot, grant, page, rd1, rd2;
  logic [15:0] rd_addr, pbuf, dword;
  always_comb begin
    ny = (y == 10'd524) ? 10'd0 : y + 10'd1;
    phase = p_tick && x[3:0] == 4'(FETCH_OFS);
    word_slot = phase && x < 10'd624;
    line_slot = phase && x == 10'd792 && ny < 10'd480;
    slot = word_slot || line_slot;
    line = word_slot ? y : ny;
    word = word_slot ? {4'd0, x[9:4]} + 10'd1 : 10'd0;
    rd_addr = {page, 15'd0} + {6'd0, line} * 16'(LINE_WORDS) + {6'd0, word};
    grant = wr_req && !slot && !wr_ack;
  end
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  logic page_q, wrap;
  assign wrap = phase && x == 10'd792 && y == 10'd524;
  assign page = wrap ? page_sel : page_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) page_q <= 1'b0;
    else if (wrap) page_q <= page_sel;
`else
  assign page = page_sel & 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= 16'd0;
      mem_we <= 1'b0;
      mem_wdata <= 16'd0;
      wr_ack <= 1'b0;
      pix <= 1'b0;
      pbuf <= 16'd0;
      dword <= 16'd0;
      rd1 <= 1'b0;
      rd2 <= 1'b0;
    end else begin
      mem_we <= grant;
      wr_ack <= grant;
      mem_addr <= slot ? rd_addr : grant ? wr_addr : mem_addr;
      mem_wdata <= grant ? wr_data : mem_wdata;
      rd1 <= slot;
      rd2 <= rd1;
      pbuf <= rd2 ? mem_rdata : pbuf;
      dword <= (p_tick && ((x[3:0] == 4'hf && x < 10'd639) || x == 10'd799)) ? pbuf : dword;
      pix <= video_on && dword[4'hf - x[3:0]];
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized host writes over scripted scan segments, checked against a frame/word-level model
module tb_vga_fb_arbiter;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [9:0] x = 10'd0, y = 10'd0;
  logic video_on = 1'b0, p_tick = 1'b0, page_sel = 1'b0, wr_req = 1'b0;
  logic [15:0] wr_addr = 16'd0, wr_data = 16'd0, mem_rdata = 16'd0;
  logic wr_ack, mem_we, pix;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] sram [0:65535];
  logic [15:0] mmem [0:65535];
  logic [15:0] fetched [int];
  logic exp_we, exp_ack, exp_pix, exp_pv, m_page, pend_w, chk_en, rnd, hold, psel_rnd, ok;
  logic [15:0] exp_addr, exp_wdata, pend_addr, pend_data;
  logic [9:0] px, py;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .p_tick(p_tick),
    .page_sel(page_sel), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix(pix)
  );
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at y=%0d x=%0d: got %h want %h", name, y, x, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_we", 16'(mem_we), 16'(exp_we));
      check("wr_ack", 16'(wr_ack), 16'(exp_ack));
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_wdata, exp_wdata);
      if (exp_pv) check("pix", 16'(pix), 16'(exp_pix));
    end
  end
  task automatic zero_model();
    exp_we = 1'b0; exp_ack = 1'b0; exp_addr = 16'd0; exp_wdata = 16'd0;
    exp_pix = 1'b0; exp_pv = 1'b1; m_page = 1'b0; pend_w = 1'b0;
    fetched.delete();
  endtask
  task automatic step();
    int nyl, line, word, k;
    bit s, g, pg;
    logic [15:0] ra, tmp;
    if (reset) begin
      zero_model();
      return;
    end
    if (pend_w) mmem[pend_addr] = pend_data;
    pend_w = 1'b0;
    nyl = (y == 10'd524) ? 0 : int'(y) + 1;
    s = p_tick && (int'(x) % 16 == 8) && (x < 10'd624 || (x == 10'd792 && nyl < 480));
    pg = m_page;
    if (DB && p_tick && x == 10'd792 && y == 10'd524) begin
      pg = page_sel;
      m_page = page_sel;
    end
    ra = exp_addr;
    if (s) begin
      line = (x < 10'd624) ? int'(y) : nyl;
      word = (x < 10'd624) ? int'(x) / 16 + 1 : 0;
      ra = 16'((pg ? 32'h8000 : 32'h0) + line * 40 + word);
      fetched[line * 64 + word] = mmem[ra];
    end
    g = wr_req && !s && !exp_ack;
    exp_pv = 1'b1;
    exp_pix = 1'b0;
    if (video_on) begin
      k = int'(y) * 64 + int'(x) / 16;
      if (fetched.exists(k)) begin
        tmp = fetched[k];
        exp_pix = tmp[15 - int'(x) % 16];
      end else exp_pv = 1'b0;
    end
    exp_we = g;
    exp_ack = g;
    if (s) exp_addr = ra;
    else if (g) exp_addr = wr_addr;
    if (g) begin
      exp_wdata = wr_data;
      pend_w = 1'b1;
      pend_addr = wr_addr;
      pend_data = wr_data;
    end
  endtask
  task automatic new_req();
    wr_req = 1'b1;
    wr_addr = $urandom_range(1, 0) ? 16'($urandom_range(2047, 0)) : 16'($urandom);
    if (wr_addr == 16'd1 || wr_addr == 16'd40) wr_addr = 16'd100;
    wr_data = 16'($urandom);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    step();
    if (!hold) begin
      if (wr_req && wr_ack) begin
        if (rnd && $urandom_range(1, 0) == 1) new_req();
        else wr_req = 1'b0;
      end else if (!wr_req && rnd && $urandom_range(3, 0) == 0) new_req();
    end
    if (psel_rnd) page_sel = 1'($urandom_range(1, 0));
    if (p_tick) begin
      p_tick = 1'b0;
      if (x == 10'd799) begin
        x = 10'd0;
        y = (y == 10'd524) ? 10'd0 : y + 10'd1;
      end else x = x + 10'd1;
    end else p_tick = 1'b1;
    video_on = x < 10'd640 && y < 10'd480;
  endtask
  task automatic goto(input logic [9:0] nx, input logic [9:0] nyv);
    x = nx;
    y = nyv;
    p_tick = 1'b0;
    video_on = x < 10'd640 && y < 10'd480;
    fetched.delete();
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 16'($urandom);
      mmem[i] = sram[i];
    end
    sram[1] = 16'hFFFF; mmem[1] = 16'hFFFF;
    sram[40] = 16'h8001; mmem[40] = 16'h8001;
    rnd = 1'b1; hold = 1'b0; psel_rnd = 1'b1; chk_en = 1'b0;
    zero_model();
    #2 reset = 1'b1;
    cyc();
    chk_en = 1'b1;
    for (int i = 0; i < 40 && !(x == 10'd9 && !p_tick); i++) cyc();
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_we", 16'(mem_we), 16'h0);
    check("rst_wr_ack", 16'(wr_ack), 16'h0);
    check("rst_pix", 16'(pix), 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 6000 && y != 10'd3; i++) begin
      px = x; py = y;
      cyc();
      if (py == 10'd0 && px >= 10'd9 && px <= 10'd31) check("first_frame_pix", 16'(pix), 16'h0);
      if (py == 10'd1 && px < 10'd16) check("scan_8001", 16'(pix), 16'(px == 10'd0 || px == 10'd15));
    end
    goto(10'd0, 10'd478);
    for (int i = 0; i < 8000 && y != 10'd482; i++) cyc();
    psel_rnd = 1'b0;
    page_sel = 1'b1;
    goto(10'd600, 10'd523);
    for (int i = 0; i < 4000 && !(y == 10'd524 && x == 10'd792 && p_tick); i++) cyc();
    cyc();
    check("wrap_addr", mem_addr, DB ? 16'h8000 : 16'h0000);
    check("wrap_we", 16'(mem_we), 16'h0);
    for (int i = 0; i < 200 && !(y == 10'd0 && x == 10'd0); i++) cyc();
    rnd = 1'b0;
    for (int i = 0; i < 100 && !(y == 10'd0 && x == 10'd8 && p_tick); i++) cyc();
    hold = 1'b1; wr_req = 1'b1; wr_addr = 16'h0123; wr_data = 16'hBEEF;
    cyc();
    check("coll_rd_addr", mem_addr, DB ? 16'h8001 : 16'h0001);
    check("coll_rd_we", 16'(mem_we), 16'h0);
    check("coll_rd_ack", 16'(wr_ack), 16'h0);
    cyc();
    check("coll_wr_we", 16'(mem_we), 16'h1);
    check("coll_wr_ack", 16'(wr_ack), 16'h1);
    check("coll_wr_addr", mem_addr, 16'h0123);
    check("coll_wr_data", mem_wdata, 16'hBEEF);
    wr_req = 1'b0; hold = 1'b0; rnd = 1'b1;
    for (int i = 0; i < 4000 && !(y == 10'd1 && x == 10'd300); i++) cyc();
    rnd = 1'b0;
    for (int i = 0; i < 20 && wr_req; i++) cyc();
    cyc();
    cyc();
    hold = 1'b1; wr_req = 1'b1; wr_addr = 16'h0777; wr_data = 16'h1234;
    cyc();
    check("rw_ack_before", 16'(wr_ack), 16'h1);
    check("rw_we_before", 16'(mem_we), 16'h1);
    reset = 1'b1;
    #1;
    zero_model();
    check("rw_we_reset", 16'(mem_we), 16'h0);
    check("rw_ack_reset", 16'(wr_ack), 16'h0);
    check("rw_pix_reset", 16'(pix), 16'h0);
    repeat (3) cyc();
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cyc();
      if (wr_ack) begin
        ok = 1'b1;
        check("rw_retry_addr", mem_addr, 16'h0777);
        check("rw_retry_data", mem_wdata, 16'h1234);
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL rw_retry: no wr_ack within 10 clk after reset release");
    end
    wr_req = 1'b0; hold = 1'b0; rnd = 1'b1;
    for (int i = 0; i < 4000 && y != 10'd3; i++) cyc();
    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
